// File: rtl/kv_op_scheduler.sv
// rtl/kv_op_scheduler.sv - round-robin GET/PUT/DEL scheduler in front of the key/value memory
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             per-requester command handshake (ready pulses on grant)
//   req_op/req_key/req_val          per-requester packed command fields
//   resp_valid/resp_ready           per-requester response handshake
//   resp_status/resp_val            shared response payload (OK/NOT_FOUND/FULL/BAD_OP, GET data)
//   mem_key/mem_wval/mem_write/mem_delete/mem_idx   memory command outputs
//   mem_hit/mem_hit_idx/mem_rval/mem_free_idx/mem_full  combinational memory lookup results

module kv_op_scheduler #(
    parameter int NUM_ENTRIES = 16,
    parameter int NUM_REQ     = 2,
    parameter int KEY_W       = 32,
    parameter int VAL_W       = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [2*NUM_REQ-1:0]     req_op,
    input  logic [KEY_W*NUM_REQ-1:0] req_key,
    input  logic [VAL_W*NUM_REQ-1:0] req_val,
    output logic [NUM_REQ-1:0]       resp_valid,
    input  logic [NUM_REQ-1:0]       resp_ready,
    output logic [1:0]               resp_status,
    output logic [VAL_W-1:0]         resp_val,
    output logic [KEY_W-1:0]         mem_key,
    output logic [VAL_W-1:0]         mem_wval,
    output logic                     mem_write,
    output logic                     mem_delete,
    output logic [NUM_ENTRIES-1:0]   mem_idx,
    input  logic                     mem_hit,
    input  logic [NUM_ENTRIES-1:0]   mem_hit_idx,
    input  logic [VAL_W-1:0]         mem_rval,
    input  logic [NUM_ENTRIES-1:0]   mem_free_idx,
    input  logic                     mem_full
);

    localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] OP_GET = 2'b00;
    localparam logic [1:0] OP_PUT = 2'b01;
    localparam logic [1:0] OP_DEL = 2'b10;
    localparam logic [1:0] OP_BAD = 2'b11;

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_NF   = 2'b01;
    localparam logic [1:0] ST_FULL = 2'b10;
    localparam logic [1:0] ST_BAD  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_EXEC   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [RR_W-1:0]        rr_ptr;
    logic [RR_W-1:0]        gnt_q;
    logic [1:0]             op_q;
    logic [KEY_W-1:0]       key_q;
    logic [VAL_W-1:0]       val_q;
    logic [1:0]             status_q;
    logic [VAL_W-1:0]       resp_val_q;
    logic                   hit_q;
    logic [NUM_ENTRIES-1:0] hit_idx_q;
    logic [VAL_W-1:0]       rval_q;
    logic [NUM_ENTRIES-1:0] free_idx_q;
    logic                   full_q;

    logic                   gnt_found;
    logic [RR_W-1:0]        gnt_sel;
    logic [RR_W-1:0]        cand_sel;
    logic [RR_W-1:0]        rr_next;
    logic [1:0]             sel_op;
    logic [KEY_W-1:0]       sel_key;
    logic [VAL_W-1:0]       sel_val;
    logic [1:0]             exec_status;
    int                     cand;

    // Round-robin search starting at rr_ptr; first valid requester wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_sel   = '0;
        cand      = 0;
        cand_sel  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand     = (int'(rr_ptr) + i) % NUM_REQ;
            cand_sel = RR_W'(cand);
            if (!gnt_found && req_valid[cand_sel]) begin
                gnt_found = 1'b1;
                gnt_sel   = cand_sel;
            end
        end
    end

    assign rr_next = (gnt_sel == RR_W'(NUM_REQ - 1)) ? '0 : gnt_sel + 1'b1;
    assign sel_op  = req_op[2*gnt_sel +: 2];
    assign sel_key = req_key[KEY_W*gnt_sel +: KEY_W];
    assign sel_val = req_val[VAL_W*gnt_sel +: VAL_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and all memory/handshake outputs; every output decodes from
    // state_q, so the asynchronous reset forces them to 0 immediately.
    always_comb begin
        state_d     = state_q;
        req_ready   = '0;
        resp_valid  = '0;
        mem_key     = '0;
        mem_wval    = '0;
        mem_write   = 1'b0;
        mem_delete  = 1'b0;
        mem_idx     = '0;
        exec_status = ST_OK;
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    req_ready[gnt_sel] = 1'b1;
                    state_d = (sel_op == OP_BAD) ? S_RESP : S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                mem_key  = key_q;
                mem_wval = val_q;
                state_d  = S_EXEC;
            end
            S_EXEC: begin
                mem_key  = key_q;
                mem_wval = val_q;
                state_d  = S_RESP;
                case (op_q)
                    OP_GET: exec_status = hit_q ? ST_OK : ST_NF;
                    OP_PUT: begin
                        if (hit_q) begin
                            mem_write = 1'b1;
                            mem_idx   = hit_idx_q;
                        end else if (!full_q) begin
                            mem_write = 1'b1;
                            mem_idx   = free_idx_q;
                        end else begin
                            exec_status = ST_FULL;
                        end
                    end
                    OP_DEL: begin
                        if (hit_q) begin
                            mem_delete = 1'b1;
                            mem_idx    = hit_idx_q;
                        end else begin
                            exec_status = ST_NF;
                        end
                    end
                    default: exec_status = ST_BAD;
                endcase
            end
            S_RESP: begin
                resp_valid[gnt_q] = 1'b1;
                if (resp_ready[gnt_q]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            gnt_q      <= '0;
            op_q       <= '0;
            key_q      <= '0;
            val_q      <= '0;
            status_q   <= ST_OK;
            resp_val_q <= '0;
            hit_q      <= 1'b0;
            hit_idx_q  <= '0;
            rval_q     <= '0;
            free_idx_q <= '0;
            full_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gnt_found) begin
                        gnt_q      <= gnt_sel;
                        op_q       <= sel_op;
                        key_q      <= sel_key;
                        val_q      <= sel_val;
                        rr_ptr     <= rr_next;
                        // Reserved ops skip the memory, so their status is final here.
                        status_q   <= (sel_op == OP_BAD) ? ST_BAD : ST_OK;
                        resp_val_q <= '0;
                    end
                end
                S_LOOKUP: begin
                    hit_q      <= mem_hit;
                    hit_idx_q  <= mem_hit_idx;
                    rval_q     <= mem_rval;
                    free_idx_q <= mem_free_idx;
                    full_q     <= mem_full;
                end
                S_EXEC: begin
                    status_q   <= exec_status;
                    resp_val_q <= (op_q == OP_GET && hit_q) ? rval_q : '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign resp_status = (state_q == S_RESP) ? status_q : 2'b00;
    assign resp_val    = (state_q == S_RESP) ? resp_val_q : '0;

endmodule

// File: tb/tb_kv_op_scheduler.sv
// tb/tb_kv_op_scheduler.sv - directed self-checking bench for kv_op_scheduler

module tb_kv_op_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req_op;
    logic [63:0] req_key;
    logic [63:0] req_val;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [1:0]  resp_status;
    logic [31:0] resp_val;
    logic [31:0] mem_key;
    logic [31:0] mem_wval;
    logic        mem_write;
    logic        mem_delete;
    logic [15:0] mem_idx;
    logic        mem_hit;
    logic [15:0] mem_hit_idx;
    logic [31:0] mem_rval;
    logic [15:0] mem_free_idx;
    logic        mem_full;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    kv_op_scheduler #(
        .NUM_ENTRIES(16),
        .NUM_REQ    (2),
        .KEY_W      (32),
        .VAL_W      (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_key     (req_key),
        .req_val     (req_val),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_status (resp_status),
        .resp_val    (resp_val),
        .mem_key     (mem_key),
        .mem_wval    (mem_wval),
        .mem_write   (mem_write),
        .mem_delete  (mem_delete),
        .mem_idx     (mem_idx),
        .mem_hit     (mem_hit),
        .mem_hit_idx (mem_hit_idx),
        .mem_rval    (mem_rval),
        .mem_free_idx(mem_free_idx),
        .mem_full    (mem_full)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full command from requester r: grant, lookup, exec, response, handshake.
    task automatic do_cmd(input string nm, input int r, input logic [1:0] op,
                          input logic [31:0] key, input logic [31:0] val,
                          input logic hit, input logic [15:0] hidx, input logic [31:0] rval,
                          input logic [15:0] fidx, input logic full,
                          input logic [1:0] est, input logic [31:0] evl,
                          input logic ew, input logic ed, input logic [15:0] eidx);
        logic [1:0] onehot;
        onehot = 2'(1 << r);
        @(negedge clk);
        req_valid            = onehot;
        req_op[2*r +: 2]     = op;
        req_key[32*r +: 32]  = key;
        req_val[32*r +: 32]  = val;
        mem_hit              = hit;
        mem_hit_idx          = hidx;
        mem_rval             = rval;
        mem_free_idx         = fidx;
        mem_full             = full;
        #1 chk({nm, "_grant"}, 64'(req_ready), 64'(onehot));
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        chk({nm, "_lk_key"}, 64'(mem_key), 64'(key));
        chk({nm, "_lk_pulse"}, 64'({mem_write, mem_delete}), 64'd0);
        @(negedge clk);
        #1;
        chk({nm, "_ex_wr"}, 64'(mem_write), 64'(ew));
        chk({nm, "_ex_del"}, 64'(mem_delete), 64'(ed));
        chk({nm, "_ex_idx"}, 64'(mem_idx), 64'(eidx));
        if (ew) chk({nm, "_ex_wval"}, 64'(mem_wval), 64'(val));
        @(negedge clk);
        #1;
        chk({nm, "_rsp_valid"}, 64'(resp_valid), 64'(onehot));
        chk({nm, "_rsp_status"}, 64'(resp_status), 64'(est));
        chk({nm, "_rsp_val"}, 64'(resp_val), 64'(evl));
        chk({nm, "_rsp_memkey"}, 64'(mem_key), 64'd0);
        resp_ready = onehot;
        @(negedge clk);
        resp_ready = 2'b00;
        #1 chk({nm, "_rsp_done"}, 64'(resp_valid), 64'd0);
    endtask

    initial begin
        logic [1:0] exp_seq [4];
        int k;
        int last;
        exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};

        rst_n = 1'b0;
        req_valid = '0; req_op = '0; req_key = '0; req_val = '0; resp_ready = '0;
        mem_hit = 1'b0; mem_hit_idx = '0; mem_rval = '0; mem_free_idx = '0; mem_full = 1'b0;
        #2;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_mem_outs", 64'({mem_write, mem_delete, mem_idx}), 64'd0);
        chk("rst_mem_key", 64'(mem_key), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_cmd("put_empty", 0, 2'b01, 32'h11, 32'hAA, 1'b0, 16'h0000, 32'h0, 16'h0001, 1'b0,
               2'b00, 32'h0, 1'b1, 1'b0, 16'h0001);
        do_cmd("get_hit", 0, 2'b00, 32'h11, 32'h0, 1'b1, 16'h0004, 32'hAA, 16'h0002, 1'b0,
               2'b00, 32'hAA, 1'b0, 1'b0, 16'h0000);
        do_cmd("del_miss", 1, 2'b10, 32'h22, 32'h0, 1'b0, 16'h0000, 32'h0, 16'h0002, 1'b0,
               2'b01, 32'h0, 1'b0, 1'b0, 16'h0000);
        do_cmd("del_hit", 0, 2'b10, 32'h33, 32'h0, 1'b1, 16'h0008, 32'h5, 16'h0002, 1'b0,
               2'b00, 32'h0, 1'b0, 1'b1, 16'h0008);
        do_cmd("put_full", 1, 2'b01, 32'h44, 32'hBB, 1'b0, 16'h0000, 32'h0, 16'h0000, 1'b1,
               2'b10, 32'h0, 1'b0, 1'b0, 16'h0000);

        // Reserved op from requester 1: response the cycle after accept.
        @(negedge clk);
        req_valid = 2'b10;
        req_op[3:2] = 2'b11;
        #1 chk("bad_grant", 64'(req_ready), 64'd2);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        chk("bad_rsp_valid", 64'(resp_valid), 64'd2);
        chk("bad_rsp_status", 64'(resp_status), 64'd3);
        chk("bad_no_pulse", 64'({mem_write, mem_delete}), 64'd0);
        resp_ready = 2'b10;
        @(negedge clk);
        resp_ready = 2'b00;
        #1 chk("bad_rsp_done", 64'(resp_valid), 64'd0);

        // Both requesters continuously valid: grants alternate, one every 4 cycles.
        @(negedge clk);
        req_valid = 2'b11;
        req_op = 4'b0000;
        mem_hit = 1'b1; mem_hit_idx = 16'h0004; mem_rval = 32'h77; mem_full = 1'b0;
        resp_ready = 2'b11;
        k = 0;
        last = 0;
        for (int c = 0; c < 40 && k < 4; c++) begin
            #1;
            if (req_ready != 2'b00) begin
                chk("alt_grant", 64'(req_ready), 64'(exp_seq[k]));
                if (k > 0) chk("alt_gap", 64'(c - last), 64'd4);
                last = c;
                k++;
            end
            if (k < 4) @(negedge clk);
        end
        chk("alt_count", 64'(k), 64'd4);
        @(posedge clk);
        #1 req_valid = 2'b00;
        repeat (4) @(negedge clk);
        resp_ready = 2'b00;
        #1 chk("alt_idle", 64'(resp_valid), 64'd0);

        // Response held off for 5 cycles with requester 1 still asking.
        @(negedge clk);
        req_valid = 2'b11;
        #1 chk("hold_grant", 64'(req_ready), 64'd1);
        repeat (3) @(negedge clk);
        resp_ready = 2'b10;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("hold_valid", 64'(resp_valid), 64'd1);
            chk("hold_status", 64'(resp_status), 64'd0);
            chk("hold_val", 64'(resp_val), 64'h77);
            chk("hold_no_ready", 64'(req_ready), 64'd0);
            @(negedge clk);
        end
        resp_ready = 2'b01;
        @(negedge clk);
        resp_ready = 2'b00;
        #1;
        chk("b2b_grant", 64'(req_ready), 64'd2);
        chk("b2b_resp_clear", 64'(resp_valid), 64'd0);
        @(posedge clk);
        #1 req_valid = 2'b00;
        resp_ready = 2'b10;
        repeat (4) @(negedge clk);
        resp_ready = 2'b00;
        #1 chk("b2b_done", 64'(resp_valid), 64'd0);

        // Reset asserted during EXEC of a PUT from requester 0.
        @(negedge clk);
        req_valid = 2'b01;
        req_op = 4'b0101;
        req_key[31:0] = 32'h55; req_val[31:0] = 32'h66;
        mem_hit = 1'b0; mem_free_idx = 16'h0002; mem_full = 1'b0;
        #1 chk("rstx_grant", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        #1 chk("rstx_write_pre", 64'(mem_write), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rstx_write", 64'(mem_write), 64'd0);
        chk("rstx_idx", 64'(mem_idx), 64'd0);
        chk("rstx_key", 64'(mem_key), 64'd0);
        chk("rstx_resp", 64'(resp_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 2'b11;
        #1 chk("rstx_rr_zero", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1 req_valid = 2'b00;
        resp_ready = 2'b11;
        repeat (4) @(negedge clk);
        resp_ready = 2'b00;
        #1 chk("rstx_done", 64'(resp_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
